alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that borrows the shared 16-bit ripple ALU to run unsigned multiply (shift-add) and unsigned divide (restoring) for the RISC datapath. While busy it drives the ALU's operand and control inputs (op, binvert, carryin) through the datapath operand muxes, selected by alu_owned. It iterates once per bit and returns a 32-bit result with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand width; also the iteration count.
CNT_W, 5, iteration counter width; must be at least clog2(WIDTH+1).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
opcode  in  1  0 = MUL, 1 = DIVU; latched with start
src_a  in  WIDTH  multiplicand or dividend
src_b  in  WIDTH  multiplier or divisor
alu_owned  out  1  datapath must route alu_* to the ALU
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_op  out  2  ALU function: 00 AND, 01 OR, 10 ADD, 11 SLT
alu_binvert  out  1  ALU B-invert
alu_carryin  out  1  ALU bit-0 carry-in
alu_result  in  WIDTH  ALU result, combinational in the same cycle
alu_carryout  in  1  ALU MSB carry-out
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
result_lo  out  WIDTH  product[15:0] or quotient
result_hi  out  WIDTH  product[31:16] or remainder
div_by_zero  out  1  last DIVU had a zero divisor

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including result_lo, result_hi and div_by_zero.
  - Reset asserted mid-operation aborts the operation. The ALU is released the next cycle and no done is produced.
- States: IDLE, ITER, DONE.
- IDLE:
  - alu_owned = 0 and all alu_* outputs = 0.
  - If start = 1 at edge N, latch the operands and opcode, clear div_by_zero, load cnt = WIDTH, and go to ITER.
  - Exception: DIVU with src_b = 0 goes straight to DONE with result_lo = 0xFFFF, result_hi = src_a, div_by_zero = 1.
- ITER:
  - busy = 1 and alu_owned = 1. Each cycle is one iteration; cnt decrements.
  - Leave to DONE after the iteration with cnt = 1, so ITER occupies cycles N+1..N+16.
- MUL iteration (registers acc = hi, mq = lo, md = multiplicand):
  - Drive alu_a = acc, alu_b = md, op = 10, binvert = 0, carryin = 0.
  - If mq[0] = 1: {acc, mq} <= {carryout, alu_result, mq[15:1]}.
  - If mq[0] = 0: {acc, mq} <= {1'b0, acc, mq[15:1]}.
- DIVU iteration (registers rem = hi, q = lo, dv = divisor):
  - Form the shifted value {msb, r_sh} = {rem, q[15]}.
  - Drive alu_a = r_sh, alu_b = dv, op = 10, binvert = 1, carryin = 1 (subtract).
  - If msb | alu_carryout: rem <= alu_result, q <= {q[14:0], 1}.
  - Otherwise: rem <= r_sh, q <= {q[14:0], 0}.
  - The msb path covers remainders of 2^15 and above.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle (N+17; N+1 for divide-by-zero).
  - result_lo, result_hi and div_by_zero are valid here and held until the next accepted start.
  - Return to IDLE on the following cycle.
- start while busy (ITER or DONE) is ignored, with no queuing.
- start is accepted only in IDLE, so the earliest back-to-back start is at the cycle after DONE.
- Operand inputs are don't-care except at the accept edge.

Optional Feature:
ALU_SEQ_ZERO_SKIP_EN:
- Defined: a MUL with src_a = 0 or src_b = 0 goes directly to DONE with result 0, giving done at N+1. The ALU is never claimed (alu_owned stays 0).
- Undefined: all MULs take the full 16 iterations, with done at N+17.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants OP_MUL and OP_DIVU;
  - ALU function codes ALU_AND, ALU_OR, ALU_ADD, ALU_SLT;
  - the state enum;
  - ITER_COUNT = WIDTH.
- The datapath decoder imports the same ALU codes.
- One natural sub-module: alu_seq_counter. It is a loadable down-counter with a last flag, reset by reset and loaded on accept.

Test Plan:
1. MUL 0x1234 × 0x5678 -> done at N+17; result_hi = 0x0626, result_lo = 0x0060; alu_owned high for cycles N+1..N+16.
2. MUL 0xFFFF × 0xFFFF -> result_hi = 0xFFFE, result_lo = 0x0001 (exercises the carryout path).
3. DIVU 0x03E8 / 0x0007 -> result_lo = 0x008E, result_hi = 0x0006, div_by_zero = 0, done at N+17.
4. DIVU 0xFFFF / 0x8000 -> quotient 0x0001, remainder 0x7FFF. DIVU 0x1234 / 0 -> done at N+1, lo = 0xFFFF, hi = 0x1234, div_by_zero = 1.
5. start pulsed at N+5 during a MUL -> ignored, exactly one done. reset at N+8 -> IDLE at N+9, outputs 0, no done. A new start at N+10 then completes normally.
6. With ALU_SEQ_ZERO_SKIP_EN defined, MUL 0 × 0x1234 -> done at N+1, result 0, alu_owned never set. With it undefined, done at N+17, result 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the multiply/divide sequencer and the
//               datapath operand decoder: opcode encodings, ALU function
//               codes, sequencer state encoding and default iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Default operand width; one shift-add / restoring step per bit.
    localparam int ALU_SEQ_WIDTH = 16;
    localparam int ITER_COUNT    = ALU_SEQ_WIDTH;

    // Sequencer opcodes, latched with start.
    localparam logic OP_MUL  = 1'b0;
    localparam logic OP_DIVU = 1'b1;

    // Shared ripple-ALU function select.
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_counter
// Description : Loadable down-counter with a "last iteration" flag. Load has
//               priority over decrement; the count saturates at zero.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load/i_load_val - load a new iteration count
//               i_dec           - decrement by one
//               o_last          - count currently equals one
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = i_load_val;
        end else if (i_dec && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_last = (r_cnt_q == CNT_W'(1));

endmodule : alu_seq_counter
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Multi-cycle unsigned multiply (shift-add) and divide
//               (restoring) sequencer that borrows the shared ripple ALU one
//               iteration per bit and returns a 2*WIDTH result.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               start, opcode         - request (IDLE only), 0 MUL / 1 DIVU
//               src_a, src_b          - multiplicand/dividend, multiplier/divisor
//               alu_owned, alu_a/b, alu_op, alu_binvert, alu_carryin
//                                     - ALU operand/control drive while owned
//               alu_result, alu_carryout - combinational ALU return path
//               busy, done            - handshake (done is a one-cycle pulse)
//               result_lo, result_hi  - product low/high or quotient/remainder
//               div_by_zero           - last DIVU had a zero divisor
// Options     : ALU_SEQ_ZERO_SKIP_EN - MUL with a zero operand completes
//               immediately without claiming the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT,
    parameter int CNT_W = 5             // must hold WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             opcode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             alu_owned,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_binvert,
    output logic             alu_carryin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    seq_state_t       r_state_q, w_state_d;
    logic             r_op_q,    w_op_d;
    logic [WIDTH-1:0] r_hi_q,    w_hi_d;   // acc (MUL) / remainder (DIVU)
    logic [WIDTH-1:0] r_lo_q,    w_lo_d;   // mq  (MUL) / quotient  (DIVU)
    logic [WIDTH-1:0] r_md_q,    w_md_d;   // multiplicand / divisor
    logic             r_dbz_q,   w_dbz_d;
    logic             r_busy_q;
    logic             r_done_q;
    logic             r_owned_q;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_last;
    logic [WIDTH-1:0] w_r_sh;
    logic             w_msb;
    logic             w_sub_ok;

    alu_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(WIDTH)),
        .i_dec      (w_cnt_dec),
        .o_last     (w_last)
    );

    // Restoring-divide shift: the bit shifted out of the remainder (w_msb)
    // is the 17th bit of the partial remainder. When set, the value already
    // exceeds any WIDTH-bit divisor, so the subtraction must be taken even
    // though the ALU carry-out cannot see that bit.
    assign w_r_sh   = {r_hi_q[WIDTH-2:0], r_lo_q[WIDTH-1]};
    assign w_msb    = r_hi_q[WIDTH-1];
    assign w_sub_ok = w_msb | alu_carryout;

    // ALU drive: zero whenever the sequencer does not own the ALU.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = ALU_AND;
        alu_binvert = 1'b0;
        alu_carryin = 1'b0;
        if (r_state_q == ST_ITER) begin
            alu_op = ALU_ADD;
            alu_b  = r_md_q;
            if (r_op_q == OP_DIVU) begin
                alu_a       = w_r_sh;
                alu_binvert = 1'b1;   // A + ~B + 1 = A - B
                alu_carryin = 1'b1;
            end else begin
                alu_a = r_hi_q;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;
        w_md_d     = r_md_q;
        w_dbz_d    = r_dbz_q;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_op_d     = opcode;
                    w_dbz_d    = 1'b0;
                    w_cnt_load = 1'b1;
                    w_hi_d     = '0;
                    w_state_d  = ST_ITER;
                    if (opcode == OP_MUL) begin
                        w_md_d = src_a;
                        w_lo_d = src_b;
`ifdef ALU_SEQ_ZERO_SKIP_EN
                        if ((src_a == '0) || (src_b == '0)) begin
                            w_lo_d    = '0;
                            w_state_d = ST_DONE;
                        end
`endif
                    end else begin
                        w_md_d = src_b;
                        w_lo_d = src_a;
                        if (src_b == '0) begin
                            w_lo_d    = '1;
                            w_hi_d    = src_a;
                            w_dbz_d   = 1'b1;
                            w_state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_ITER: begin
                w_cnt_dec = 1'b1;
                if (r_op_q == OP_MUL) begin
                    // Shift {carry, sum-or-acc, mq} right by one.
                    if (r_lo_q[0]) begin
                        w_hi_d = {alu_carryout, alu_result[WIDTH-1:1]};
                        w_lo_d = {alu_result[0], r_lo_q[WIDTH-1:1]};
                    end else begin
                        w_hi_d = {1'b0, r_hi_q[WIDTH-1:1]};
                        w_lo_d = {r_hi_q[0], r_lo_q[WIDTH-1:1]};
                    end
                end else begin
                    w_hi_d = w_sub_ok ? alu_result : w_r_sh;
                    w_lo_d = {r_lo_q[WIDTH-2:0], w_sub_ok};
                end
                if (w_last) begin
                    w_state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_op_q    <= OP_MUL;
            r_hi_q    <= '0;
            r_lo_q    <= '0;
            r_md_q    <= '0;
            r_dbz_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_owned_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_hi_q    <= w_hi_d;
            r_lo_q    <= w_lo_d;
            r_md_q    <= w_md_d;
            r_dbz_q   <= w_dbz_d;
            r_busy_q  <= (w_state_d != ST_IDLE);
            r_done_q  <= (w_state_d == ST_DONE);
            r_owned_q <= (w_state_d == ST_ITER);
        end
    end

    assign alu_owned   = r_owned_q;
    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign result_lo   = r_lo_q;
    assign result_hi   = r_hi_q;
    assign div_by_zero = r_dbz_q;

endmodule : alu_seq_ctrl
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl with a behavioural model
//               of the shared ripple ALU and a result scoreboard.
// Options     : ALU_SEQ_ZERO_SKIP_EN - changes expected zero-operand latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         opcode = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         alu_owned;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [1:0]   alu_op;
    logic         alu_binvert, alu_carryin, alu_carryout;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_owned    (alu_owned),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_binvert  (alu_binvert),
        .alu_carryin  (alu_carryin),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .busy         (busy),
        .done         (done),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .div_by_zero  (div_by_zero)
    );

    // Shared ripple ALU model.
    logic [W-1:0] m_b;
    logic [W:0]   m_sum;
    always_comb begin
        m_b          = alu_binvert ? ~alu_b : alu_b;
        m_sum        = {1'b0, alu_a} + {1'b0, m_b} + {{W{1'b0}}, alu_carryin};
        alu_carryout = m_sum[W];
        case (alu_op)
            ALU_AND: alu_result = alu_a & m_b;
            ALU_OR:  alu_result = alu_a | m_b;
            ALU_ADD: alu_result = m_sum[W-1:0];
            ALU_SLT: alu_result = {{(W-1){1'b0}}, m_sum[W-1]};
            default: alu_result = '0;
        endcase
    end

    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [31:0] p;
        if (op == OP_MUL) begin
            p     = {16'h0, a} * {16'h0, b};
            e.lo  = p[15:0];
            e.hi  = p[31:16];
            e.dbz = 1'b0;
        end else if (b == '0) begin
            e.lo  = 16'hFFFF;
            e.hi  = a;
            e.dbz = 1'b1;
        end else begin
            e.lo  = a / b;
            e.hi  = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic int exp_latency(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        if ((op == OP_DIVU) && (b == '0)) return 1;
`ifdef ALU_SEQ_ZERO_SKIP_EN
        if ((op == OP_MUL) && ((a == '0) || (b == '0))) return 1;
`else
        if (a == 16'hDEAD && a != a) return 0;  // keeps both arguments referenced
`endif
        return 17;
    endfunction

    // Runs one operation starting from an IDLE cycle (called at a negedge).
    // poke_at > 0 re-pulses start at that sample to check it is ignored.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, input string tag);
        exp_t e, got;
        int   lat = 0, owned = 0, ndone = 0, xlat, xowned;
        bit   ctrl_bad = 1'b0, idle_bad = 1'b0;
        xlat   = exp_latency(op, a, b);
        xowned = (xlat == 17) ? 16 : 0;
        sb_q.push_back(model(op, a, b));
        start = 1'b1; opcode = op; src_a = a; src_b = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; opcode = ~op; src_a = W'($urandom); src_b = W'($urandom);
            end
            if (poke_at != 0 && k == poke_at) begin
                start = 1'b1; src_a = W'($urandom); src_b = W'($urandom);
            end
            if (poke_at != 0 && k == poke_at + 1) start = 1'b0;
            if (alu_owned === 1'b1) begin
                owned++;
                if (alu_op !== ALU_ADD || alu_binvert !== op || alu_carryin !== op || busy !== 1'b1)
                    ctrl_bad = 1'b1;
            end else if (alu_owned !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_op !== ALU_AND ||
                         alu_binvert !== 1'b0 || alu_carryin !== 1'b0) begin
                ctrl_bad = 1'b1;
            end
            if (lat == 0 && done !== 1'b1 && busy !== 1'b1) ctrl_bad = 1'b1;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    e   = sb_q.pop_front();
                    got.lo = result_lo; got.hi = result_hi; got.dbz = div_by_zero;
                    n_vec++;
                    if (got.lo !== e.lo || got.hi !== e.hi || got.dbz !== e.dbz || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s result: got lo=%h hi=%h dbz=%b busy=%b want lo=%h hi=%h dbz=%b busy=1",
                                 tag, got.lo, got.hi, got.dbz, busy, e.lo, e.hi, e.dbz);
                    end
                end
            end
            if (lat != 0 && k == lat + 1) begin
                if (busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
                if (poke_at == 0) break;
            end
        end
        if (lat == 0) sb_q.delete();
        n_vec++;
        if (lat != xlat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d (0 = timeout)", tag, lat, xlat);
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d want 1", tag, ndone);
        end
        n_vec++;
        if (owned != xowned || ctrl_bad) begin
            n_err++;
            $display("FAIL %s alu_ctrl: owned %0d cycles (want %0d), ctrl_bad=%0d want 0",
                     tag, owned, xowned, ctrl_bad);
        end
        n_vec++;
        if (idle_bad) begin
            n_err++;
            $display("FAIL %s return_idle: busy=%b done=%b want 0 0", tag, busy, done);
        end
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, alu_owned, div_by_zero} !== 4'b0 || result_lo !== '0 || result_hi !== '0 ||
            alu_a !== '0 || alu_b !== '0 || alu_op !== 2'b00 || alu_binvert !== 1'b0 || alu_carryin !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got busy=%b done=%b own=%b dbz=%b lo=%h hi=%h a=%h b=%h op=%b want all 0",
                     tag, busy, done, alu_owned, div_by_zero, result_lo, result_hi, alu_a, alu_b, alu_op);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 16'h1234, 16'h5678, 0, "mul_1234x5678");
        run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0, "mul_ffffxffff");
        run_op(OP_MUL, 16'h8001, 16'h0003, 0, "mul_8001x0003");
    endtask

    task automatic test_divu();
        run_op(OP_DIVU, 16'h03E8, 16'h0007, 0, "div_03e8_0007");
        run_op(OP_DIVU, 16'hFFFF, 16'h8000, 0, "div_ffff_8000");
        run_op(OP_DIVU, 16'hFFFF, 16'hFFFF, 0, "div_ffff_ffff");
        run_op(OP_DIVU, 16'h1234, 16'h0000, 0, "div_by_zero");
    endtask

    task automatic test_zero_operand();
        run_op(OP_MUL, 16'h0000, 16'h1234, 0, "mul_0x1234");
        run_op(OP_MUL, 16'h1234, 16'h0000, 0, "mul_1234x0");
    endtask

    task automatic test_start_while_busy();
        run_op(OP_MUL, 16'hBEEF, 16'h0101, 5, "mul_start_ignored");
    endtask

    task automatic test_reset_abort();
        start = 1'b1; opcode = OP_MUL; src_a = 16'h4321; src_b = 16'h00FF;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 8) reset = 1'b1;
        end
        reset = 1'b0;
        n_vec++;
        if ({busy, done, alu_owned, div_by_zero} !== 4'b0 || result_lo !== '0 || result_hi !== '0) begin
            n_err++;
            $display("FAIL reset_abort: got busy=%b done=%b own=%b dbz=%b lo=%h hi=%h want all 0",
                     busy, done, alu_owned, div_by_zero, result_lo, result_hi);
        end
        run_op(OP_MUL, 16'h00FF, 16'h0101, 0, "mul_after_abort");
    endtask

    task automatic test_back_to_back();
        logic         op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = W'($urandom);
            b  = (i == 3) ? 16'h0001 : W'($urandom);
            run_op(op, a, b, 0, "back_to_back");
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset("reset_state");
        test_mul();
        test_divu();
        test_reset("reset_clears_dbz");
        test_zero_operand();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_seq_ctrl
`default_nettype wire
